// File: rtl/jt1943_dwnld_map_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jt1943_dwnld_pkg
//  Description : Shared types and the byte-to-SDRAM address mapping helper
//                for the ROM-download mapper.
//  Revision    : 1.0 - initial release
// ============================================================================
package jt1943_dwnld_pkg;

    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        logic [21:0] addr;
        logic [7:0]  data;
        logic [1:0]  mask;
    } prog_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } dwnld_state_t;

    // Graphics bytes are rebased to the region start before halving, so the
    // byte lane comes from the rebased address rather than the raw one.
    function automatic prog_entry_t map_entry(
        input logic [21:0] a,
        input logic [7:0]  d,
        input logic [21:0] gfx_start,
        input logic [21:0] gfx_offset
    );
        prog_entry_t e;
        logic [21:0] rel;
        logic        is_gfx;
        is_gfx = (a >= gfx_start);
        rel    = is_gfx ? (a - gfx_start) : a;
        e.addr = is_gfx ? ({1'b0, rel[21:1]} + gfx_offset) : {1'b0, rel[21:1]};
        e.data = d;
        e.mask = rel[0] ? 2'b01 : 2'b10;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jt1943_dwnld_map_if.sv
`default_nettype none
// ============================================================================
//  Module      : jt1943_dwnld_map_if
//  Description : HPS download stream, SDRAM programming port and PROM bus.
//  Revision    : 1.0 - initial release
// ============================================================================
interface jt1943_dwnld_map_if;
    logic        downloading;
    logic        ioctl_wr;
    logic [21:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        prog_rdy;
    logic        prog_we;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        prom_we;
    logic [10:0] prom_addr;
    logic [7:0]  prom_data;
    logic        loop_rst;
    logic        dwnld_done;
    logic        overflow;

    modport master (
        output downloading, ioctl_wr, ioctl_addr, ioctl_data, prog_rdy,
        input  prog_we, prog_addr, prog_data, prog_mask,
        input  prom_we, prom_addr, prom_data, loop_rst, dwnld_done, overflow
    );

    modport slave (
        input  downloading, ioctl_wr, ioctl_addr, ioctl_data, prog_rdy,
        output prog_we, prog_addr, prog_data, prog_mask,
        output prom_we, prom_addr, prom_data, loop_rst, dwnld_done, overflow
    );
endinterface
`default_nettype wire

// File: rtl/jt1943_dwnld_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : jt1943_dwnld_fifo
//  Description : Small synchronous FIFO of SDRAM program entries; a push is
//                accepted when full as long as a pop happens the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module jt1943_dwnld_fifo
    import jt1943_dwnld_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  prog_entry_t din,
    output prog_entry_t dout,
    output logic        full,
    output logic        empty
);
    localparam int                  c_addr_w = $clog2(FIFO_DEPTH);
    localparam logic [c_addr_w:0]   c_full   = (c_addr_w + 1)'(FIFO_DEPTH);
    localparam logic [c_addr_w-1:0] c_ptr_1  = 1;
    localparam logic [c_addr_w:0]   c_cnt_1  = 1;

    prog_entry_t         r_mem [FIFO_DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_addr_w:0]   r_count;
    logic                w_do_push;
    logic                w_do_pop;

    assign full      = (r_count == c_full);
    assign empty     = (r_count == '0);
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign dout      = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_1;
                2'b01:   r_count <= r_count - c_cnt_1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end
endmodule
`default_nettype wire

// File: rtl/jt1943_dwnld_map.sv
`default_nettype none
// ============================================================================
//  Module      : jt1943_dwnld_map
//  Description : Maps the HPS download byte stream onto SDRAM word writes and
//                PROM strobes, and sequences the game reset around the load.
//  Revision    : 1.0 - initial release
// ============================================================================
module jt1943_dwnld_map
    import jt1943_dwnld_pkg::*;
#(
    parameter logic [21:0] GFX_START  = 22'h1_8000,
    parameter logic [21:0] GFX_OFFSET = 22'h10_0000,
    parameter logic [21:0] PROM_START = 22'h3_C000
)(
    input  logic               clk,
    input  logic               rst,
    jt1943_dwnld_map_if.slave  bus
);
    dwnld_state_t r_state;
    dwnld_state_t w_state_nxt;
    logic         r_dl_q;
    logic         w_dl_rise;
    logic         w_is_prom;
    logic         w_push;
    logic         w_pop;
    logic         w_drop;
    logic         w_full;
    logic         w_empty;
    logic         w_loop_rst;
    logic         w_done;
    logic [10:0]  w_prom_addr;
    prog_entry_t  w_entry;
    prog_entry_t  w_head;
    logic         r_prom_we;
    logic [10:0]  r_prom_addr;
    logic [7:0]   r_prom_data;
    logic         r_overflow;

    assign w_is_prom   = (bus.ioctl_addr >= PROM_START);
    assign w_prom_addr = bus.ioctl_addr[10:0] - PROM_START[10:0];
    assign w_entry     = map_entry(bus.ioctl_addr, bus.ioctl_data, GFX_START, GFX_OFFSET);
    assign w_push      = bus.ioctl_wr & ~w_is_prom;
    assign w_pop       = ~w_empty & bus.prog_rdy;
    assign w_drop      = w_push & w_full & ~w_pop;
    assign w_dl_rise   = bus.downloading & ~r_dl_q;

    jt1943_dwnld_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_entry),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    // The FIFO head is the programming register; blank it when nothing is queued.
    assign bus.prog_we    = ~w_empty;
    assign bus.prog_addr  = w_empty ? '0 : w_head.addr;
    assign bus.prog_data  = w_empty ? '0 : w_head.data;
    assign bus.prog_mask  = w_empty ? '0 : w_head.mask;
    assign bus.prom_we    = r_prom_we;
    assign bus.prom_addr  = r_prom_addr;
    assign bus.prom_data  = r_prom_data;
    assign bus.loop_rst   = w_loop_rst;
    assign bus.dwnld_done = w_done;
    assign bus.overflow   = r_overflow;

    always_comb begin
        w_state_nxt = r_state;
        w_loop_rst  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_dl_rise) w_state_nxt = LOAD;
            end
            LOAD: begin
                w_loop_rst = 1'b1;
                if (!bus.downloading) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                w_loop_rst = 1'b1;
                if (w_dl_rise)    w_state_nxt = LOAD;
                else if (w_empty) w_state_nxt = DONE;
            end
            DONE: begin
                w_loop_rst  = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = w_dl_rise ? LOAD : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_dl_q      <= 1'b0;
            r_prom_we   <= 1'b0;
            r_prom_addr <= '0;
            r_prom_data <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_dl_q    <= bus.downloading;
            r_prom_we <= bus.ioctl_wr & w_is_prom;
            if (bus.ioctl_wr & w_is_prom) begin
                r_prom_addr <= w_prom_addr;
                r_prom_data <= bus.ioctl_data;
            end
            // A new download clears the flag, but a drop in that same cycle still counts.
            if (w_dl_rise)   r_overflow <= w_drop;
            else if (w_drop) r_overflow <= 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_jt1943_dwnld_map.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jt1943_dwnld_map
//  Description : Self-checking bench for the ROM-download mapper.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jt1943_dwnld_map;
    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    jt1943_dwnld_map_if bus ();

    jt1943_dwnld_map dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit is_prom;
        int word;
        int mask;
        int prom_addr;
    } map_t;

    typedef struct {
        int addr;
        int data;
        bit e_we;
        int e_addr;
        int e_mask;
        bit e_prom;
        int e_paddr;
    } vec_t;

    typedef struct {
        int word;
        int data;
        int mask;
    } q_ent_t;

    // Region rules written as plain integer arithmetic.
    function automatic map_t ref_map(int a);
        map_t m;
        m.is_prom = 0; m.word = 0; m.mask = 0; m.prom_addr = 0;
        if (a >= 'h3C000) begin
            m.is_prom   = 1;
            m.prom_addr = (a - 'h3C000) % 2048;
        end else if (a >= 'h18000) begin
            m.word = ((a - 'h18000) / 2 + 'h100000) % 'h400000;
            m.mask = ((a - 'h18000) % 2 == 1) ? 1 : 2;
        end else begin
            m.word = a / 2;
            m.mask = (a % 2 == 1) ? 1 : 2;
        end
        return m;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit wr, int a, int d, bit rdy);
        bus.ioctl_wr   = wr;
        bus.ioctl_addr = 22'(a);
        bus.ioctl_data = 8'(d);
        bus.prog_rdy   = rdy;
    endtask

    task automatic chk_head(string nm, int a, int d);
        map_t m;
        m = ref_map(a);
        chk({nm, "_we"},   bus.prog_we, 1);
        chk({nm, "_addr"}, bus.prog_addr, m.word);
        chk({nm, "_data"}, bus.prog_data, d);
        chk({nm, "_mask"}, bus.prog_mask, m.mask);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.downloading = 1'b0;
        drive(0, 0, 0, 0);
        tick();
        chk("rst_prog_we",  bus.prog_we, 0);
        chk("rst_prog_addr", bus.prog_addr, 0);
        chk("rst_prom_we",  bus.prom_we, 0);
        chk("rst_loop_rst", bus.loop_rst, 0);
        chk("rst_done",     bus.dwnld_done, 0);
        chk("rst_overflow", bus.overflow, 0);
        rst = 1'b0;
    endtask

    vec_t   vt [10];
    q_ent_t q[$];

    initial begin
        int   done_cnt;
        bit   ovf_m;
        bit   prom_pend;
        int   prom_a_m;
        int   prom_d_m;
        map_t m;

        vt[0] = '{'h000003, 'h5A, 1, 'h000001, 1, 0, 0};
        vt[1] = '{'h018004, 'h11, 1, 'h100002, 2, 0, 0};
        vt[2] = '{'h03C010, 'h22, 0, 0, 0, 1, 'h010};
        vt[3] = '{'h000000, 'h33, 1, 'h000000, 2, 0, 0};
        vt[4] = '{'h017FFF, 'h44, 1, 'h00BFFF, 1, 0, 0};
        vt[5] = '{'h018000, 'h55, 1, 'h100000, 2, 0, 0};
        vt[6] = '{'h03BFFF, 'h66, 1, 'h111FFF, 1, 0, 0};
        vt[7] = '{'h03C000, 'h77, 0, 0, 0, 1, 'h000};
        vt[8] = '{'h3FFFFF, 'h88, 0, 0, 0, 1, 'h7FF};
        vt[9] = '{'h03C801, 'h99, 0, 0, 0, 1, 'h001};

        do_reset();

        // Single bytes with the writer always ready.
        for (int i = 0; i < 10; i++) begin
            drive(1, vt[i].addr, vt[i].data, 1);
            tick();
            drive(0, 0, 0, 1);
            chk("tbl_prog_we", bus.prog_we, vt[i].e_we);
            if (vt[i].e_we) begin
                chk("tbl_prog_addr", bus.prog_addr, vt[i].e_addr);
                chk("tbl_prog_data", bus.prog_data, vt[i].data);
                chk("tbl_prog_mask", bus.prog_mask, vt[i].e_mask);
            end
            chk("tbl_prom_we", bus.prom_we, vt[i].e_prom);
            if (vt[i].e_prom) begin
                chk("tbl_prom_addr", bus.prom_addr, vt[i].e_paddr);
                chk("tbl_prom_data", bus.prom_data, vt[i].data);
            end
            tick();
            chk("tbl_prog_we_once", bus.prog_we, 0);
            chk("tbl_prom_we_once", bus.prom_we, 0);
        end

        // Back-pressure: four queued bytes, frozen head, fifth byte dropped.
        for (int i = 0; i < 4; i++) begin
            drive(1, 'h100 + i, 'hA0 + i, 0);
            tick();
            chk_head("bp_fill", 'h100, 'hA0);
        end
        drive(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_head("bp_hold", 'h100, 'hA0);
            chk("bp_no_ovf", bus.overflow, 0);
        end
        drive(1, 'h104, 'hA4, 0);
        tick();
        chk("bp_overflow", bus.overflow, 1);
        chk_head("bp_after_drop", 'h100, 'hA0);
        drive(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            chk_head("bp_release", 'h100 + i, 'hA0 + i);
            tick();
        end
        chk("bp_drained", bus.prog_we, 0);

        // Full load sequence; the rising edge also clears the sticky overflow.
        bus.downloading = 1'b1;
        drive(0, 0, 0, 0);
        tick();
        chk("seq_loop_rst_rise", bus.loop_rst, 1);
        chk("seq_ovf_cleared", bus.overflow, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 'h300 + i, 'hC0 + i, 0);
            tick();
        end
        bus.downloading = 1'b0;
        drive(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("seq_hold_loop_rst", bus.loop_rst, 1);
            chk("seq_hold_done", bus.dwnld_done, 0);
        end
        drive(0, 0, 0, 1);
        done_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            chk("seq_prog_we", bus.prog_we, (c < 3) ? 1 : 0);
            if (c < 3) chk_head("seq_order", 'h300 + c, 'hC0 + c);
            chk("seq_done", bus.dwnld_done, (c == 4) ? 1 : 0);
            chk("seq_loop_rst", bus.loop_rst, (c <= 4) ? 1 : 0);
            if (bus.dwnld_done) done_cnt++;
            tick();
        end
        chk("seq_done_count", done_cnt, 1);

        // Nothing pending: DRAIN then DONE on the following cycles.
        bus.downloading = 1'b1;
        tick();
        bus.downloading = 1'b0;
        tick();
        chk("np_n1_done", bus.dwnld_done, 0);
        chk("np_n1_loop_rst", bus.loop_rst, 1);
        tick();
        chk("np_n2_done", bus.dwnld_done, 1);
        chk("np_n2_loop_rst", bus.loop_rst, 1);
        tick();
        chk("np_n3_done", bus.dwnld_done, 0);
        chk("np_n3_loop_rst", bus.loop_rst, 0);

        // Full FIFO with a simultaneous accept and new byte: nothing lost.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 'h200 + i, 'hB0 + i, 0);
            tick();
        end
        drive(1, 'h204, 'hB4, 1);
        tick();
        chk("pp_no_ovf", bus.overflow, 0);
        drive(0, 0, 0, 1);
        for (int i = 1; i < 5; i++) begin
            chk_head("pp_order", 'h200 + i, 'hB0 + i);
            tick();
        end
        chk("pp_drained", bus.prog_we, 0);
        chk("pp_no_ovf_end", bus.overflow, 0);

        // Reset mid-transfer discards the queue.
        bus.downloading = 1'b1;
        drive(0, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 'h400 + i, 'hD0 + i, 0);
            tick();
        end
        rst = 1'b1;
        bus.downloading = 1'b0;
        drive(0, 0, 0, 0);
        tick();
        rst = 1'b0;
        chk("mr_prog_we", bus.prog_we, 0);
        chk("mr_loop_rst", bus.loop_rst, 0);
        drive(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mr_no_write", bus.prog_we, 0);
            chk("mr_idle", bus.loop_rst | bus.dwnld_done, 0);
        end

        // Randomized traffic against a queue-based model.
        do_reset();
        bus.downloading = 1'b1;
        tick();
        q.delete();
        ovf_m = 0; prom_pend = 0; prom_a_m = 0; prom_d_m = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit wr;
            bit rdy;
            int a;
            int d;
            int region;
            chk("rnd_prog_we", bus.prog_we, (q.size() > 0) ? 1 : 0);
            if (q.size() > 0) begin
                chk("rnd_prog_addr", bus.prog_addr, q[0].word);
                chk("rnd_prog_data", bus.prog_data, q[0].data);
                chk("rnd_prog_mask", bus.prog_mask, q[0].mask);
            end
            chk("rnd_prom_we", bus.prom_we, prom_pend);
            if (prom_pend) begin
                chk("rnd_prom_addr", bus.prom_addr, prom_a_m);
                chk("rnd_prom_data", bus.prom_data, prom_d_m);
            end
            chk("rnd_overflow", bus.overflow, ovf_m);
            chk("rnd_loop_rst", bus.loop_rst, 1);

            wr     = ($urandom_range(99) < 60);
            rdy    = ($urandom_range(99) < 45);
            region = $urandom_range(2);
            case (region)
                0:       a = $urandom_range('h17FFF);
                1:       a = $urandom_range('h3BFFF, 'h18000);
                default: a = $urandom_range('h3FFFFF, 'h3C000);
            endcase
            d = $urandom_range(255);
            drive(wr, a, d, rdy);

            if (q.size() > 0 && rdy) void'(q.pop_front());
            prom_pend = 0;
            if (wr) begin
                m = ref_map(a);
                if (m.is_prom) begin
                    prom_pend = 1;
                    prom_a_m  = m.prom_addr;
                    prom_d_m  = d;
                end else if (q.size() < 4) begin
                    q.push_back('{m.word, d, m.mask});
                end else begin
                    ovf_m = 1;
                end
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
